// File: rtl/cmul_combine_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : cmul_combine_stage_if
// Description : Handshake and data bundle for the complex-multiplier
//               recombination stage.
//               Upstream side : in_valid, in_ready, ac, bd, ad, bc
//               Downstream side: out_valid, out_ready, re, im, out_ovf
//               The master modport is the environment around the stage.
//               The slave modport is the stage itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface cmul_combine_stage_if #(
    parameter int W = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] ac;
    logic [W-1:0] bd;
    logic [W-1:0] ad;
    logic [W-1:0] bc;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   re;
    logic [W:0]   im;
    logic         out_ovf;

    modport master (
        output in_valid, ac, bd, ad, bc, out_ready,
        input  in_ready, out_valid, re, im, out_ovf
    );

    modport slave (
        input  in_valid, ac, bd, ad, bc, out_ready,
        output in_ready, out_valid, re, im, out_ovf
    );
endinterface
`default_nettype wire

// File: rtl/cmul_combine_stage.sv
`default_nettype none
// ============================================================================
// Module      : cmul_combine_stage
// Description : Two-stage recombination of the four partial products of a
//               complex multiplier: re = ac - bd, im = ad + bc, each exact in
//               W+1 bits.  Every add/subtract is split: the low halves are
//               summed in stage 1 and their carries registered, and the high
//               halves are summed in stage 2.  Latency 2, throughput 1/cycle.
// Ports       : clk       - rising-edge clock
//               rst       - asynchronous active-high reset
//               bus.in_*  - input handshake and products ac, bd, ad, bc
//               bus.out_* - output handshake, re, im, out_ovf
// Options     : CMUL_SAT_EN - when defined, re/im are clamped to the W-bit
//               signed range and out_ovf flags a clamp.  When undefined,
//               re/im are exact and out_ovf is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module cmul_combine_stage #(
    parameter int W = 64
) (
    input  wire                    clk,
    input  wire                    rst,
    cmul_combine_stage_if.slave    bus
);
    localparam int HALF = W / 2;

    // ---------------------------------------------------------------- control
    logic w_s2_load;
    logic w_s1_adv;
    logic w_in_ready;
    logic w_in_fire;

    logic r_s1_valid;
    logic r_s2_valid;

    // The output register can be refilled when it is empty or being drained.
    assign w_s2_load  = !r_s2_valid || bus.out_ready;
    assign w_s1_adv   = r_s1_valid && w_s2_load;
    assign w_in_ready = !r_s1_valid || w_s1_adv;
    assign w_in_fire  = bus.in_valid && w_in_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_s2_valid;

    // ---------------------------------------------------------- stage 1 math
    // The extra top bit of each sum is the carry into the high half.
    // Subtraction uses the inverted operand with carry-in 1.
    logic [HALF:0] w_re_lo_sum;
    logic [HALF:0] w_im_lo_sum;

    assign w_re_lo_sum = {1'b0, bus.ac[HALF-1:0]} + {1'b0, ~bus.bd[HALF-1:0]}
                       + {{HALF{1'b0}}, 1'b1};
    assign w_im_lo_sum = {1'b0, bus.ad[HALF-1:0]} + {1'b0, bus.bc[HALF-1:0]};

    logic            r_cr;
    logic            r_ci;
    logic [HALF-1:0] r_re_lo;
    logic [HALF-1:0] r_im_lo;
    logic [HALF-1:0] r_ac_hi;
    logic [HALF-1:0] r_bd_hi;
    logic [HALF-1:0] r_ad_hi;
    logic [HALF-1:0] r_bc_hi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_cr       <= 1'b0;
            r_ci       <= 1'b0;
            r_re_lo    <= '0;
            r_im_lo    <= '0;
            r_ac_hi    <= '0;
            r_bd_hi    <= '0;
            r_ad_hi    <= '0;
            r_bc_hi    <= '0;
        end else begin
            // When stage 1 is free (or emptying) it takes whatever is
            // offered; with no offer it goes empty.
            if (w_in_ready) begin
                r_s1_valid <= bus.in_valid;
            end
            if (w_in_fire) begin
                r_cr    <= w_re_lo_sum[HALF];
                r_ci    <= w_im_lo_sum[HALF];
                r_re_lo <= w_re_lo_sum[HALF-1:0];
                r_im_lo <= w_im_lo_sum[HALF-1:0];
                r_ac_hi <= bus.ac[W-1:HALF];
                r_bd_hi <= bus.bd[W-1:HALF];
                r_ad_hi <= bus.ad[W-1:HALF];
                r_bc_hi <= bus.bc[W-1:HALF];
            end
        end
    end

    // ---------------------------------------------------------- stage 2 math
    // High halves are sign-extended by one bit so the W+1 bit result is
    // exact; the registered low-half carries close the split adders.
    logic [HALF:0] w_re_hi;
    logic [HALF:0] w_im_hi;
    logic [W:0]    w_re_full;
    logic [W:0]    w_im_full;

    assign w_re_hi = {r_ac_hi[HALF-1], r_ac_hi}
                   + ~{r_bd_hi[HALF-1], r_bd_hi}
                   + {{HALF{1'b0}}, r_cr};
    assign w_im_hi = {r_ad_hi[HALF-1], r_ad_hi}
                   + {r_bc_hi[HALF-1], r_bc_hi}
                   + {{HALF{1'b0}}, r_ci};

    assign w_re_full = {w_re_hi, r_re_lo};
    assign w_im_full = {w_im_hi, r_im_lo};

    logic [W:0] w_re_next;
    logic [W:0] w_im_next;
    logic       w_ovf_next;

`ifdef CMUL_SAT_EN
    localparam logic [W:0] c_sat_max = {2'b00, {(W-1){1'b1}}};
    localparam logic [W:0] c_sat_min = {2'b11, {(W-1){1'b0}}};

    // A W+1 bit value fits W signed bits exactly when its top two bits agree.
    logic w_re_ovf;
    logic w_im_ovf;

    assign w_re_ovf   = w_re_full[W] ^ w_re_full[W-1];
    assign w_im_ovf   = w_im_full[W] ^ w_im_full[W-1];
    assign w_re_next  = w_re_ovf ? (w_re_full[W] ? c_sat_min : c_sat_max) : w_re_full;
    assign w_im_next  = w_im_ovf ? (w_im_full[W] ? c_sat_min : c_sat_max) : w_im_full;
    assign w_ovf_next = w_re_ovf || w_im_ovf;
`else
    assign w_re_next  = w_re_full;
    assign w_im_next  = w_im_full;
    assign w_ovf_next = 1'b0;
`endif

    logic [W:0] r_re;
    logic [W:0] r_im;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_re       <= '0;
            r_im       <= '0;
        end else begin
            if (w_s2_load) begin
                r_s2_valid <= r_s1_valid;
            end
            // Data only changes when a real item moves in, so a stalled
            // result stays stable.
            if (w_s1_adv) begin
                r_re <= w_re_next;
                r_im <= w_im_next;
            end
        end
    end

    assign bus.re = r_re;
    assign bus.im = r_im;

`ifdef CMUL_SAT_EN
    logic r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_s1_adv) begin
            r_ovf <= w_ovf_next;
        end
    end

    assign bus.out_ovf = r_ovf;
`else
    assign bus.out_ovf = w_ovf_next;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cmul_combine_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmul_combine_stage
// Description : Self-checking bench for cmul_combine_stage (W = 64).
//               Directed vector table, backpressure and mid-flight reset
//               sequences, and a randomized stream checked against an
//               arithmetic reference model through a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmul_combine_stage;
    localparam int W = 64;

    logic clk;
    logic rst;

    cmul_combine_stage_if #(.W(W)) bus ();

    cmul_combine_stage #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] ac;
        logic [W-1:0] bd;
        logic [W-1:0] ad;
        logic [W-1:0] bc;
        logic [W:0]   re;
        logic [W:0]   im;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W:0] re;
        logic [W:0] im;
        logic       ovf;
    } res_t;

    int   tests;
    int   fails;
    int   n_out;
    res_t sbq[$];

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain signed arithmetic on the whole values.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] c, input logic [W-1:0] d);
        res_t             m;
        logic signed [W:0] r;
        logic signed [W:0] i;
`ifdef CMUL_SAT_EN
        logic signed [W:0] maxv;
        logic signed [W:0] minv;
`endif
        r = $signed({a[W-1], a}) - $signed({b[W-1], b});
        i = $signed({c[W-1], c}) + $signed({d[W-1], d});
        m.ovf = 1'b0;
`ifdef CMUL_SAT_EN
        maxv = (65'sd1 <<< (W-1)) - 65'sd1;
        minv = -(65'sd1 <<< (W-1));
        if (r > maxv) begin r = maxv; m.ovf = 1'b1; end
        else if (r < minv) begin r = minv; m.ovf = 1'b1; end
        if (i > maxv) begin i = maxv; m.ovf = 1'b1; end
        else if (i < minv) begin i = minv; m.ovf = 1'b1; end
`endif
        m.re = r;
        m.im = i;
        return m;
    endfunction

    function automatic logic [W-1:0] rnd64();
        case ($urandom_range(0, 4))
            0:       return 64'h7FFF_FFFF_FFFF_FFFF;
            1:       return 64'h8000_0000_0000_0000;
            2:       return {32'h0, $urandom};
            3:       return {{32{1'b1}}, $urandom};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Called at a falling edge with inputs already applied.  Scores any
    // output transfer, records any input transfer, then moves to the next
    // falling edge.
    task automatic step(output bit in_fire);
        res_t e;
        #1;
        in_fire = bus.in_valid && bus.in_ready;
        if (bus.out_valid && bus.out_ready) begin
            n_out++;
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_spurious: got out_valid=1 re=%h, expected no output", bus.re);
            end else begin
                e = sbq.pop_front();
                chk("sb_re",  bus.re, e.re);
                chk("sb_im",  bus.im, e.im);
                chk("sb_ovf", {64'h0, bus.out_ovf}, {64'h0, e.ovf});
            end
        end
        if (in_fire) sbq.push_back(model(bus.ac, bus.bd, bus.ad, bus.bc));
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] d);
        bus.in_valid = v;
        bus.ac = a;
        bus.bd = b;
        bus.ad = c;
        bus.bc = d;
    endtask

    // Single transfer with out_ready held high; result must appear exactly
    // two cycles after acceptance.
    task automatic run_vec(input vec_t v, input string tag);
        bit f;
        bus.out_ready = 1'b1;
        drive(1'b1, v.ac, v.bd, v.ad, v.bc);
        step(f);
        chk({tag, "_accept"}, {64'h0, f}, 65'd1);
        drive(1'b0, '0, '0, '0, '0);
        chk({tag, "_valid_n1"}, {64'h0, bus.out_valid}, 65'd0);
        step(f);
        chk({tag, "_valid_n2"}, {64'h0, bus.out_valid}, 65'd1);
        chk({tag, "_re"}, bus.re, v.re);
        chk({tag, "_im"}, bus.im, v.im);
        chk({tag, "_ovf"}, {64'h0, bus.out_ovf}, {64'h0, v.ovf});
        step(f);
    endtask

    vec_t vecs[5];

    initial begin
        bit         f;
        int         idx;
        int         acc;
        logic [W:0] held_re;
        logic [W:0] held_im;

        tests = 0;
        fails = 0;
        n_out = 0;

        vecs[0] = '{64'd5, 64'd3, 64'd2, 64'd7, 65'd2, 65'd9, 1'b0};
        vecs[1] = '{64'd0, 64'd1, -64'sd4, 64'd1,
                    65'h1_FFFF_FFFF_FFFF_FFFF, 65'h1_FFFF_FFFF_FFFF_FFFD, 1'b0};
        vecs[2] = '{64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000,
                    65'h0_0000_0001_0000_0000, 65'h0_0000_0001_0000_0000, 1'b0};
`ifdef CMUL_SAT_EN
        vecs[3] = '{64'd0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                    65'd0, 65'h0_7FFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[4] = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 64'd0,
                    65'h1_8000_0000_0000_0000, 65'd0, 1'b1};
`else
        vecs[3] = '{64'd0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                    65'd0, 65'h0_FFFF_FFFF_FFFF_FFFE, 1'b0};
        vecs[4] = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 64'd0,
                    65'h1_0000_0000_0000_0001, 65'd0, 1'b0};
`endif

        // ---------------------------------------------------------- reset
        rst = 1'b1;
        bus.out_ready = 1'b0;
        drive(1'b0, '0, '0, '0, '0);
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {64'h0, bus.out_valid}, 65'd0);
        chk("rst_re", bus.re, 65'd0);
        chk("rst_im", bus.im, 65'd0);
        chk("rst_ovf", {64'h0, bus.out_ovf}, 65'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {64'h0, bus.in_ready}, 65'd1);

        // -------------------------------------------------- directed table
        for (int k = 0; k < 5; k++) begin
            run_vec(vecs[k], $sformatf("vec%0d", k));
        end

        // ---------------------------------------------------- backpressure
        bus.out_ready = 1'b0;
        idx = 0;
        acc = 0;
        held_re = '0;
        held_im = '0;
        for (int c = 0; c < 6; c++) begin
            drive(idx < 4, 64'(idx * 100 + 11), 64'(idx + 3), 64'(idx * 7), 64'(-idx));
            chk($sformatf("bp_in_ready_c%0d", c), {64'h0, bus.in_ready}, {64'h0, (c < 2)});
            if (c >= 2) begin
                chk($sformatf("bp_out_valid_c%0d", c), {64'h0, bus.out_valid}, 65'd1);
                if (c == 2) begin
                    held_re = bus.re;
                    held_im = bus.im;
                end else begin
                    chk($sformatf("bp_re_stable_c%0d", c), bus.re, held_re);
                    chk($sformatf("bp_im_stable_c%0d", c), bus.im, held_im);
                end
            end
            step(f);
            if (f) begin
                idx++;
                acc++;
            end
        end
        chk("bp_accepts_while_stalled", 65'(acc), 65'd2);
        n_out = 0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && (idx < 4 || sbq.size() != 0); c++) begin
            drive(idx < 4, 64'(idx * 100 + 11), 64'(idx + 3), 64'(idx * 7), 64'(-idx));
            step(f);
            if (f) idx++;
        end
        drive(1'b0, '0, '0, '0, '0);
        chk("bp_all_emitted", 65'(n_out), 65'd4);
        chk("bp_sb_empty", 65'(sbq.size()), 65'd0);

        // ---------------------------------------------------------- random
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, rnd64(), rnd64(), rnd64(), rnd64());
            bus.out_ready = $urandom_range(0, 9) < 7;
            step(f);
        end
        drive(1'b0, '0, '0, '0, '0);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10 && sbq.size() != 0; c++) step(f);
        chk("rand_drain_empty", 65'(sbq.size()), 65'd0);

        // ------------------------------------------------ reset mid-flight
        bus.out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 64'(c + 40), 64'd1, 64'd2, 64'd3);
            step(f);
        end
        drive(1'b0, '0, '0, '0, '0);
        chk("mid_out_valid_before", {64'h0, bus.out_valid}, 65'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_async_out_valid", {64'h0, bus.out_valid}, 65'd0);
        chk("mid_async_re", bus.re, 65'd0);
        chk("mid_async_im", bus.im, 65'd0);
        @(negedge clk);
        rst = 1'b0;
        sbq.delete();
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("mid_in_ready_after", {64'h0, bus.in_ready}, 65'd1);
        run_vec(vecs[0], "post_rst");
        chk("final_sb_empty", 65'(sbq.size()), 65'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/cmul_combine_stage.md
Name: cmul_combine_stage

Overview:
- Pipelined recombination stage downstream of the four partial-product multipliers in the complex multiplier.
- Inputs: signed products ac, bd, ad, bc. Outputs: re = ac - bd and im = ad + bc, full precision.
- Each add/subtract is a split ripple carry: low half in stage 1, carry registered, high half in stage 2. Latency 2 cycles.
- Valid/ready handshake on both sides, full throughput of 1 result per cycle.

Parameters:
- W, 64, product width in bits (two's complement); must be even; HALF = W/2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  products valid
- in_ready  output  1  stage can accept this cycle
- ac  input  W  signed product a*c
- bd  input  W  signed product b*d
- ad  input  W  signed product a*d
- bc  input  W  signed product b*c
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts
- re  output  W+1  signed real part ac - bd
- im  output  W+1  signed imaginary part ad + bc
- out_ovf  output  1  result exceeds W-bit signed range (see Optional Feature)

Behaviour:
- Reset (async, active-high): s1_valid = 0, s2_valid = 0, out_valid = 0, re = 0, im = 0, out_ovf = 0, in_ready = 1 once rst deasserts. All data registers cleared.
- Handshake:
  - Input transfer when in_valid & in_ready. Output transfer when out_valid & out_ready.
  - out_valid = s2_valid. re, im, out_ovf held stable while out_valid & !out_ready.
  - s2 loads when !s2_valid | out_ready.
  - s1 advances into s2 when s1_valid and s2 loads.
  - in_ready = !s1_valid | s1 advances. Combinational from out_ready, no combinational path from in_valid.
- Stage 1 (accept cycle), registered:
  - {cr, r_lo} = ac[HALF-1:0] + ~bd[HALF-1:0] + 1
  - {ci, i_lo} = ad[HALF-1:0] + bc[HALF-1:0] + 0
  - Upper halves of ac, bd, ad, bc registered unchanged.
- Stage 2:
  - Operands sign-extended to HALF+1 bits: re_hi = ac_hi_ext + ~bd_hi_ext + cr, im_hi = ad_hi_ext + bc_hi_ext + ci, each keeping HALF+1 bits.
  - re = {re_hi, r_lo}, im = {im_hi, i_lo}, both exact (W+1)-bit two's complement.
- Latency: a result accepted at cycle N appears with out_valid at cycle N+2 when there is no backpressure.
- Back-to-back inputs produce one output per cycle. Order is preserved, with no drop or duplication.
- Full pipeline (s1 and s2 valid) with out_ready = 0: in_ready = 0, all registers hold.
- Simultaneous accept and emit: the new item enters s1 while the old s1 item moves to s2 in the same edge.
- Wrap: ac - bd with ac = most-negative and bd = most-positive is still exact in W+1 bits. There is no internal overflow.
- Reset mid-operation: in-flight items are discarded and out_valid drops immediately (async).

Optional Feature:
- Macro: CMUL_SAT_EN.
- Defined:
  - In stage 2, if re (or im) lies outside the W-bit signed range, it is clamped to +(2^(W-1)-1) or -2^(W-1), sign-extended to W+1 bits.
  - out_ovf = 1 for that result if either part was clamped.
- Undefined:
  - re and im are exact, with no clamp logic.
  - out_ovf is tied to 0.

Test Plan:
- ac=5, bd=3, ad=2, bc=7, single transfer, out_ready=1 -> out_valid exactly 2 cycles later, re=2, im=9, out_ovf=0.
- ac=0, bd=1, ad=-4, bc=1 -> re=65'h1_FFFF_FFFF_FFFF_FFFF (-1), im=-3. Checks the borrow across halves.
- ac=64'h0000_0000_FFFF_FFFF, bd=-1, ad=bc=64'h0000_0000_8000_0000 -> re=65'h0_0000_0001_0000_0000, im=65'h0_0000_0001_0000_0000. Checks the carry from the low half into the high half.
- ad=bc=64'h7FFF_FFFF_FFFF_FFFF -> without CMUL_SAT_EN: im=65'h0_FFFF_FFFF_FFFF_FFFE, out_ovf=0. With CMUL_SAT_EN: im=65'h0_7FFF_FFFF_FFFF_FFFF, out_ovf=1.
- Backpressure: 4 items offered back-to-back, out_ready=0 for 6 cycles then 1 -> in_ready drops after 2 accepts, outputs stable while stalled, all 4 emitted in order, none lost.
- Assert rst while 2 items are in flight -> out_valid=0, re=0, im=0 asynchronously. After release, in_ready=1 and the next input emerges after 2 cycles with correct values.
